// File: rtl/lap_hold_bcd.sv
// Stopwatch display stage: binary seconds to BCD, lap freeze, and a small
// lap memory with sequential recall. All outputs are registered on counter_clk.
module lap_hold_bcd #(
    parameter int DEPTH = 4,
    parameter int IDXW  = 2
) (
    input  logic            counter_clk,
    input  logic            filtered_rst,
    input  logic            clr_pulse,
    input  logic            lap_pulse,
    input  logic            recall_pulse,
    input  logic [3:0]      cnt_min,
    input  logic [7:0]      cnt_sec,
    input  logic [3:0]      cnt_tenth,
    output logic [3:0]      dig_min,
    output logic [3:0]      dig_sec_t,
    output logic [3:0]      dig_sec_o,
    output logic [3:0]      dig_tenth,
    output logic            frozen,
    output logic [IDXW-1:0] recall_idx,
    output logic [IDXW:0]   lap_count,
    output logic            lap_full,
    output logic            sec_err
);

    typedef enum logic [1:0] {
        LIVE   = 2'd0,
        FROZEN = 2'd1,
        RECALL = 2'd2
    } state_t;

    localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(DEPTH);

    state_t          r_state;
    logic [15:0]     r_mem [DEPTH];
    logic [3:0]      r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth;
    logic            r_frozen, r_lap_full, r_sec_err;
    logic [IDXW-1:0] r_recall_idx;
    logic [IDXW:0]   r_lap_count;

    logic [3:0]      w_sec_t;
    logic [7:0]      w_rem;
    logic            w_sec_bad;
    logic [15:0]     w_live;
    logic            w_wr;
    logic [IDXW-1:0] w_idx_nxt;
    logic            w_idx_last;
    logic [15:0]     w_rd_first, w_rd_next;

    // Compare/subtract chain instead of a divider; out-of-range saturates to 59.
    always_comb begin
        w_sec_bad = (cnt_sec > 8'd59);
        w_sec_t   = 4'd0;
        w_rem     = cnt_sec;
        if (w_sec_bad) begin
            w_sec_t = 4'd5;
            w_rem   = 8'd9;
        end else if (cnt_sec >= 8'd50) begin
            w_sec_t = 4'd5;
            w_rem   = cnt_sec - 8'd50;
        end else if (cnt_sec >= 8'd40) begin
            w_sec_t = 4'd4;
            w_rem   = cnt_sec - 8'd40;
        end else if (cnt_sec >= 8'd30) begin
            w_sec_t = 4'd3;
            w_rem   = cnt_sec - 8'd30;
        end else if (cnt_sec >= 8'd20) begin
            w_sec_t = 4'd2;
            w_rem   = cnt_sec - 8'd20;
        end else if (cnt_sec >= 8'd10) begin
            w_sec_t = 4'd1;
            w_rem   = cnt_sec - 8'd10;
        end
    end

    assign w_live     = {cnt_min, w_sec_t, w_rem[3:0], cnt_tenth};
    assign w_wr       = (r_state == LIVE) && !clr_pulse && lap_pulse && !r_lap_full;
    assign w_idx_nxt  = r_recall_idx + 1'b1;
    assign w_idx_last = ({1'b0, r_recall_idx} == (r_lap_count - 1'b1));
    assign w_rd_first = r_mem[0];
    assign w_rd_next  = r_mem[w_idx_nxt];

    // Memory carries no reset; it is only ever shown for indices below lap_count.
    always_ff @(posedge counter_clk) begin
        if (w_wr)
            r_mem[r_lap_count[IDXW-1:0]] <= w_live;
    end

    always_ff @(posedge counter_clk or posedge filtered_rst) begin
        if (filtered_rst) begin
            r_state      <= LIVE;
            r_dig_min    <= 4'd0;
            r_dig_sec_t  <= 4'd0;
            r_dig_sec_o  <= 4'd0;
            r_dig_tenth  <= 4'd0;
            r_frozen     <= 1'b0;
            r_recall_idx <= '0;
            r_lap_count  <= '0;
            r_lap_full   <= 1'b0;
            r_sec_err    <= 1'b0;
        end else begin
            r_sec_err <= w_sec_bad;
            if (clr_pulse) begin
                r_state      <= LIVE;
                r_frozen     <= 1'b0;
                r_recall_idx <= '0;
                r_lap_count  <= '0;
                r_lap_full   <= 1'b0;
                {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_live;
            end else begin
                case (r_state)
                    LIVE: begin
                        if (lap_pulse) begin
                            r_state  <= FROZEN;
                            r_frozen <= 1'b1;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_live;
                            if (!r_lap_full) begin
                                r_lap_count <= r_lap_count + 1'b1;
                                r_lap_full  <= ((r_lap_count + 1'b1) == FULL_CNT);
                            end
                        end else if (recall_pulse && (r_lap_count != '0)) begin
                            r_state      <= RECALL;
                            r_frozen     <= 1'b1;
                            r_recall_idx <= '0;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_rd_first;
                        end else begin
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_live;
                        end
                    end
                    FROZEN: begin
                        if (lap_pulse) begin
                            r_state  <= LIVE;
                            r_frozen <= 1'b0;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_live;
                        end else if (recall_pulse && (r_lap_count != '0)) begin
                            r_state      <= RECALL;
                            r_recall_idx <= '0;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_rd_first;
                        end
                    end
                    RECALL: begin
                        if (lap_pulse || (recall_pulse && w_idx_last)) begin
                            r_state      <= LIVE;
                            r_frozen     <= 1'b0;
                            r_recall_idx <= '0;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_live;
                        end else if (recall_pulse) begin
                            r_recall_idx <= w_idx_nxt;
                            {r_dig_min, r_dig_sec_t, r_dig_sec_o, r_dig_tenth} <= w_rd_next;
                        end
                    end
                    default: begin
                        r_state  <= LIVE;
                        r_frozen <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dig_min    = r_dig_min;
    assign dig_sec_t  = r_dig_sec_t;
    assign dig_sec_o  = r_dig_sec_o;
    assign dig_tenth  = r_dig_tenth;
    assign frozen     = r_frozen;
    assign recall_idx = r_recall_idx;
    assign lap_count  = r_lap_count;
    assign lap_full   = r_lap_full;
    assign sec_err    = r_sec_err;

endmodule

// File: tb/tb_lap_hold_bcd.sv
// Scoreboard bench for lap_hold_bcd: directed steps push hand-computed
// expectations, a monitor pops and compares after each edge or reset rise.
module tb_lap_hold_bcd;

    logic       counter_clk = 1'b0;
    logic       filtered_rst = 1'b1;
    logic       clr_pulse = 1'b0, lap_pulse = 1'b0, recall_pulse = 1'b0;
    logic [3:0] cnt_min = 4'd0, cnt_tenth = 4'd0;
    logic [7:0] cnt_sec = 8'd0;
    logic [3:0] dig_min, dig_sec_t, dig_sec_o, dig_tenth;
    logic       frozen, lap_full, sec_err;
    logic [1:0] recall_idx;
    logic [2:0] lap_count;

    typedef struct packed {
        logic [15:0] dig;
        logic        fr;
        logic [1:0]  idx;
        logic [2:0]  cnt;
        logic        full;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stepno = 0;

    lap_hold_bcd #(.DEPTH(4), .IDXW(2)) dut (
        .counter_clk(counter_clk), .filtered_rst(filtered_rst),
        .clr_pulse(clr_pulse), .lap_pulse(lap_pulse), .recall_pulse(recall_pulse),
        .cnt_min(cnt_min), .cnt_sec(cnt_sec), .cnt_tenth(cnt_tenth),
        .dig_min(dig_min), .dig_sec_t(dig_sec_t), .dig_sec_o(dig_sec_o),
        .dig_tenth(dig_tenth), .frozen(frozen), .recall_idx(recall_idx),
        .lap_count(lap_count), .lap_full(lap_full), .sec_err(sec_err)
    );

    always #5 counter_clk = ~counter_clk;

    function automatic exp_t mk(input logic [15:0] dig, input logic fr,
                                input logic [1:0] idx, input logic [2:0] cnt,
                                input logic full, input logic err);
        exp_t e;
        e.dig = dig; e.fr = fr; e.idx = idx; e.cnt = cnt; e.full = full; e.err = err;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge; expectation applies after the next rise.
    task automatic step(input logic [3:0] m, input logic [7:0] s, input logic [3:0] t,
                        input logic c, input logic l, input logic r, input exp_t e);
        @(negedge counter_clk);
        cnt_min = m; cnt_sec = s; cnt_tenth = t;
        clr_pulse = c; lap_pulse = l; recall_pulse = r;
        stepno++;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge counter_clk or posedge filtered_rst);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = mk({dig_min, dig_sec_t, dig_sec_o, dig_tenth}, frozen,
                       recall_idx, lap_count, lap_full, sec_err);
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL chk%0d dig=%h fr=%b idx=%0d cnt=%0d full=%b err=%b expected dig=%h fr=%b idx=%0d cnt=%0d full=%b err=%b",
                             checks, a.dig, a.fr, a.idx, a.cnt, a.full, a.err,
                             e.dig, e.fr, e.idx, e.cnt, e.full, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        repeat (3) @(negedge counter_clk);
        filtered_rst = 1'b0;
        // reset state, observed through the first live edge with no events
        step(3, 47, 6, 0, 0, 0, mk(16'h3476, 0, 0, 0, 0, 0));
        step(1, 23, 4, 0, 0, 0, mk(16'h1234, 0, 0, 0, 0, 0));
        step(1, 23, 4, 0, 1, 0, mk(16'h1234, 1, 0, 1, 0, 0));
        step(1, 25, 0, 0, 0, 0, mk(16'h1234, 1, 0, 1, 0, 0));
        step(1, 25, 0, 0, 1, 0, mk(16'h1250, 0, 0, 1, 0, 0));
        step(2, 10, 1, 0, 1, 0, mk(16'h2101, 1, 0, 2, 0, 0));
        step(2, 11, 0, 0, 1, 0, mk(16'h2110, 0, 0, 2, 0, 0));
        step(3, 33, 3, 0, 1, 0, mk(16'h3333, 1, 0, 3, 0, 0));
        step(3, 34, 0, 0, 1, 0, mk(16'h3340, 0, 0, 3, 0, 0));
        step(4, 59, 9, 0, 1, 0, mk(16'h4599, 1, 0, 4, 1, 0));
        step(5,  0, 1, 0, 1, 0, mk(16'h5001, 0, 0, 4, 1, 0));
        // fifth lap while full: freezes but stores nothing
        step(6,  7, 8, 0, 1, 0, mk(16'h6078, 1, 0, 4, 1, 0));
        step(6,  9, 0, 0, 0, 0, mk(16'h6078, 1, 0, 4, 1, 0));
        step(6,  9, 0, 0, 0, 1, mk(16'h1234, 1, 0, 4, 1, 0));
        step(6, 10, 0, 0, 0, 1, mk(16'h2101, 1, 1, 4, 1, 0));
        step(6, 11, 0, 0, 0, 1, mk(16'h3333, 1, 2, 4, 1, 0));
        step(6, 12, 0, 0, 0, 1, mk(16'h4599, 1, 3, 4, 1, 0));
        step(7, 48, 9, 0, 0, 1, mk(16'h7489, 0, 0, 4, 1, 0));
        step(0,  5, 1, 1, 0, 0, mk(16'h0051, 0, 0, 0, 0, 0));
        step(0,  6, 2, 0, 0, 1, mk(16'h0062, 0, 0, 0, 0, 0));
        // lap and recall together: lap wins
        step(0,  7, 3, 0, 1, 1, mk(16'h0073, 1, 0, 1, 0, 0));
        step(0,  8, 4, 0, 1, 0, mk(16'h0084, 0, 0, 1, 0, 0));
        step(1, 60, 0, 0, 0, 0, mk(16'h1590, 0, 0, 1, 0, 1));
        step(1, 59, 0, 0, 0, 0, mk(16'h1590, 0, 0, 1, 0, 0));
        step(1,200, 0, 0, 0, 0, mk(16'h1590, 0, 0, 1, 0, 1));
        step(1,  0, 0, 0, 0, 0, mk(16'h1000, 0, 0, 1, 0, 0));
        step(2,  0, 0, 0, 1, 0, mk(16'h2000, 1, 0, 2, 0, 0));
        step(2,  1, 0, 0, 0, 1, mk(16'h0073, 1, 0, 2, 0, 0));
        step(2,  1, 0, 0, 0, 1, mk(16'h2000, 1, 1, 2, 0, 0));
        // clear mid-recall, with lap also asserted to confirm clear priority
        step(2, 22, 2, 1, 1, 0, mk(16'h2222, 0, 0, 0, 0, 0));
        step(3,  3, 3, 0, 1, 0, mk(16'h3033, 1, 0, 1, 0, 0));
        step(3,  3, 3, 0, 0, 1, mk(16'h3033, 1, 0, 1, 0, 0));
        step(3,  4, 0, 0, 1, 0, mk(16'h3040, 0, 0, 1, 0, 0));
        step(3,  5, 0, 0, 1, 0, mk(16'h3050, 1, 0, 2, 0, 0));
        step(3,  6, 0, 0, 0, 1, mk(16'h3033, 1, 0, 2, 0, 0));
        // async reset between edges, mid-recall
        @(negedge counter_clk);
        clr_pulse = 0; lap_pulse = 0; recall_pulse = 0;
        cnt_sec = 8'd70;
        #2;
        q.push_back(mk(16'h0000, 0, 0, 0, 0, 0));
        filtered_rst = 1'b1;
        repeat (2) @(negedge counter_clk);
        filtered_rst = 1'b0;
        step(4, 15, 5, 0, 0, 0, mk(16'h4155, 0, 0, 0, 0, 0));
        step(4, 16, 5, 0, 0, 1, mk(16'h4165, 0, 0, 0, 0, 0));
        step(4, 17, 5, 0, 0, 0, mk(16'h4175, 0, 0, 0, 0, 0));
        repeat (3) @(negedge counter_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
